// File: rtl/led_fade_sequencer.sv
// Breathing brightness sequencer: ramps a 4-bit level 0 -> peak -> 0 with holds at each end.
// Level changes are committed only on the last clock of each 16-clock PWM frame.
`timescale 1ns / 1ps

module led_fade_sequencer #(
    parameter int unsigned STEP_TICKS = 65536,
    parameter int unsigned HOLD_STEPS = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       enable,
    input  logic       start,
    input  logic [3:0] max_level,
    output logic [3:0] level,
    output logic       busy,
    output logic       cycle_done
);

    typedef enum logic [2:0] {StIdle, StRise, StHoldHi, StFall, StHoldLo} state_e;

    localparam logic [23:0] PrescLast = 24'(STEP_TICKS - 1);
    localparam logic [7:0]  HoldLast  = 8'(HOLD_STEPS - 1);

    state_e      state_q, state_d;
    logic [3:0]  target_q, target_d;
    logic [3:0]  max_q, max_d;
    logic [7:0]  hold_cnt_q, hold_cnt_d;
    logic [23:0] presc_q;
    logic [3:0]  frame_cnt_q;
    logic [3:0]  level_q;
    logic        presc_clr;
    logic        step_tick;
    logic        hold_last;

    assign step_tick = (state_q != StIdle) && (presc_q == PrescLast);
    assign hold_last = (hold_cnt_q == HoldLast);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            target_q   <= 4'd0;
            max_q      <= 4'd0;
            hold_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            max_q      <= max_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // Losing enable during the rising half short-circuits to FALL, even on a tick.
    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        max_d      = max_q;
        hold_cnt_d = hold_cnt_q;
        presc_clr  = 1'b0;
        unique case (state_q)
            StIdle: begin
                target_d = 4'd0;
                if (start && enable) begin
                    max_d     = max_level;
                    presc_clr = 1'b1;
                    state_d   = StRise;
                end
            end
            StRise: begin
                if (!enable) begin
                    state_d = StFall;
                end else if (step_tick) begin
                    if (target_q < max_q) begin
                        target_d = target_q + 4'd1;
                    end else begin
                        hold_cnt_d = 8'd0;
                        state_d    = StHoldHi;
                    end
                end
            end
            StHoldHi: begin
                if (!enable) begin
                    state_d = StFall;
                end else if (step_tick) begin
                    if (hold_last) state_d = StFall;
                    else           hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            StFall: begin
                if (step_tick) begin
                    if (target_q != 4'd0) begin
                        target_d = target_q - 4'd1;
                    end else begin
                        hold_cnt_d = 8'd0;
                        state_d    = StHoldLo;
                    end
                end
            end
            StHoldLo: begin
                if (step_tick) begin
                    if (hold_last) begin
                        if (enable) begin
                            max_d     = max_level;
                            presc_clr = 1'b1;
                            state_d   = StRise;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        hold_cnt_d = hold_cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy       = (state_q != StIdle);
        cycle_done = (state_q == StHoldLo) && step_tick && hold_last;
        level      = level_q;
    end

    // Frame counter mirrors the PWM counter so level only moves between PWM periods.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            presc_q     <= 24'd0;
            frame_cnt_q <= 4'd0;
            level_q     <= 4'd0;
        end else begin
            if (presc_clr || (state_q == StIdle) || step_tick) presc_q <= 24'd0;
            else                                               presc_q <= presc_q + 24'd1;
            frame_cnt_q <= frame_cnt_q + 4'd1;
            if (frame_cnt_q == 4'hF) level_q <= target_q;
        end
    end

endmodule

// File: tb/tb_led_fade_sequencer.sv
// Directed bench for led_fade_sequencer with STEP_TICKS=4, HOLD_STEPS=2; all expected levels
// and pulse times are hand-derived from cycle counts since the last reset release.
`timescale 1ns / 1ps

module tb_led_fade_sequencer;

    localparam int Base  = 208;           // first frame-aligned start
    localparam int Base3 = Base + 288;    // cycle entry latching max_level=0
    localparam int Base4 = Base3 + 48;    // cycle entry latching max_level=15
    localparam int Base5 = Base4 + 96;    // start for the reset-during-hold test

    logic       clk = 1'b0;
    logic       resetn;
    logic       enable;
    logic       start;
    logic [3:0] max_level;
    logic [3:0] level;
    logic       busy;
    logic       cycle_done;

    int cyc;
    int cd_total;
    int lvl_max;
    int act_cnt;
    int win_open = 0;
    int n_cmp = 0;
    int n_err = 0;
    int cd_snap;

    // Level sampled at B+16j (and held to B+16j+15): cycle peaking at 15, then cycles peaking at 3.
    int lvl_tab[16] = '{0, 3, 7, 11, 15, 14, 10, 6, 2, 0, 3, 2, 0, 3, 2, 0};

    led_fade_sequencer #(
        .STEP_TICKS(4),
        .HOLD_STEPS(2)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .enable     (enable),
        .start      (start),
        .max_level  (max_level),
        .level      (level),
        .busy       (busy),
        .cycle_done (cycle_done)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    always_ff @(posedge clk) begin
        cd_total <= cd_total + (cycle_done ? 1 : 0);
        if (win_open == 0) begin
            lvl_max <= 0;
            act_cnt <= 0;
        end else begin
            if (int'(level) > lvl_max) lvl_max <= int'(level);
            if (level != 4'd0 || busy || cycle_done) act_cnt <= act_cnt + 1;
        end
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic to_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn    = 1'b0;
        enable    = 1'b0;
        start     = 1'b0;
        max_level = 4'd0;
        cd_total  = 0;
        repeat (3) @(negedge clk);
        check_val("rst_level", int'(level), 0);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_done", int'(cycle_done), 0);
        resetn   = 1'b1;
        win_open = 1;
        to_cyc(200);
        check_val("idle_activity", act_cnt, 0);
        win_open = 0;

        // Full cycles; start while busy and a max_level change during FALL must not disturb.
        enable    = 1'b1;
        max_level = 4'd15;
        to_cyc(Base - 1);
        start = 1'b1;
        to_cyc(Base);
        start   = 1'b0;
        cd_snap = cd_total;
        check_val("run_busy", int'(busy), 1);
        for (int j = 0; j < 16; j++) begin
            to_cyc(Base + 16 * j);
            check_val("frame_start_lvl", int'(level), lvl_tab[j]);
            if (j == 3) begin
                to_cyc(Base + 50);
                start = 1'b1;
                to_cyc(Base + 51);
                start = 1'b0;
            end
            if (j == 6) begin
                to_cyc(Base + 100);
                max_level = 4'd3;
            end
            to_cyc(Base + 16 * j + 15);
            check_val("frame_end_lvl", int'(level), lvl_tab[j]);
            if (j == 8) check_val("done_pulse15", int'(cycle_done), 1);
        end
        check_val("done_count", cd_total - cd_snap, 3);
        check_val("still_busy", int'(busy), 1);

        // max_level=0: level stays 0, cycle_done after 24 clocks.
        to_cyc(Base + 256);
        max_level = 4'd0;
        to_cyc(Base3);
        win_open = 1;
        cd_snap  = cd_total;
        to_cyc(Base3 + 22);
        check_val("zero_done_early", int'(cycle_done), 0);
        to_cyc(Base3 + 23);
        check_val("zero_done", int'(cycle_done), 1);
        to_cyc(Base3 + 30);
        max_level = 4'd15;
        to_cyc(Base3 + 48);
        check_val("zero_lvl_max", lvl_max, 0);
        check_val("zero_done_cnt", cd_total - cd_snap, 2);
        check_val("zero_busy", int'(busy), 1);
        win_open = 0;

        // enable drops on the tick that would raise target 6 -> 7.
        to_cyc(Base4);
        win_open = 1;
        to_cyc(Base4 + 16);
        check_val("en_lvl_16", int'(level), 3);
        to_cyc(Base4 + 27);
        enable = 1'b0;
        to_cyc(Base4 + 32);
        check_val("en_lvl_32", int'(level), 6);
        to_cyc(Base4 + 48);
        check_val("en_lvl_48", int'(level), 2);
        to_cyc(Base4 + 63);
        check_val("en_done", int'(cycle_done), 1);
        check_val("en_busy_end", int'(busy), 1);
        to_cyc(Base4 + 64);
        check_val("en_idle_busy", int'(busy), 0);
        check_val("en_idle_done", int'(cycle_done), 0);
        check_val("en_idle_lvl", int'(level), 0);
        check_val("en_lvl_max", lvl_max, 6);
        win_open = 0;
        to_cyc(Base4 + 70);
        enable = 1'b1;
        to_cyc(Base4 + 90);
        check_val("no_start_busy", int'(busy), 0);
        check_val("no_start_lvl", int'(level), 0);

        // Reset asserted in HOLD_HI at level 15, then a clean restart.
        to_cyc(Base5 - 1);
        start = 1'b1;
        to_cyc(Base5);
        start = 1'b0;
        to_cyc(Base5 + 64);
        check_val("pre_rst_lvl", int'(level), 15);
        to_cyc(Base5 + 66);
        resetn = 1'b0;
        #1;
        check_val("async_rst_lvl", int'(level), 0);
        check_val("async_rst_busy", int'(busy), 0);
        check_val("async_rst_done", int'(cycle_done), 0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        to_cyc(15);
        start = 1'b1;
        to_cyc(16);
        start = 1'b0;
        for (int j = 0; j < 5; j++) begin
            to_cyc(16 + 16 * j);
            check_val("restart_lvl", int'(level), lvl_tab[j]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
